// File: rtl/nexusv_bus_pkg.sv
// nexusv_bus_pkg: shared state/master encodings and defaults for the peripheral bus arbiter.
package nexusv_bus_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
    typedef enum logic {M_CORE = 1'b0, M_DBG = 1'b1} master_e;
    localparam int TIMEOUT_CYCLES_DEF = 255;
endpackage

// File: rtl/nexusv_rr_arb2.sv
// nexusv_rr_arb2: combinational 2-way round-robin pick; on a tie the master that was not served last wins.
module nexusv_rr_arb2
    import nexusv_bus_pkg::*;
(
    input  logic [1:0] i_req,
    input  master_e    i_last,
    output logic [1:0] o_gnt
);
    assign o_gnt = (i_req == 2'b11) ? ((i_last == M_DBG) ? 2'b01 : 2'b10) : i_req;
endmodule

// File: rtl/nexusv_bus_arbiter.sv
// nexusv_bus_arbiter: shares the peripheral bus between core (m0) and debug/DMA (m1), grant locked per transfer.
// Define BUS_TIMEOUT_EN to abort stalled transfers with an error after TIMEOUT_CYCLES busy cycles.
module nexusv_bus_arbiter
    import nexusv_bus_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int TO_CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_write,
    input  logic              m0_valid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    output logic              m0_err,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_write,
    input  logic              m1_valid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              m1_err,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_write,
    output logic              s_valid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,
    output logic [1:0]        grant
);
    state_e     r_state;
    master_e    r_owner;
    master_e    r_last;
    logic [1:0] r_grant;
    logic [1:0] w_gnt;
    logic       w_act;
    logic       w_own_valid;
    logic       w_to;
    logic       w_done;
    logic       w_cpl;

    nexusv_rr_arb2 u_rr (
        .i_req  ({m1_valid, m0_valid}),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    // A reset cycle suppresses slave access and completions even while still BUSY
    assign w_act       = (r_state == ST_BUSY) & ~rst;
    assign w_own_valid = (r_owner == M_DBG) ? m1_valid : m0_valid;

`ifdef BUS_TIMEOUT_EN
    logic [TO_CNT_W-1:0] r_cnt;
    always_ff @(posedge clk)
        if (rst || r_state == ST_IDLE) r_cnt <= '0;
        else r_cnt <= r_cnt + TO_CNT_W'(1);
    assign w_to = w_act & w_own_valid & ~s_ready & (r_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [TO_CNT_W-1:0] w_unused_to;
    assign w_unused_to = TO_CNT_W'(TIMEOUT_CYCLES);
    assign w_to        = 1'b0;
`endif

    assign s_valid = w_act & w_own_valid & ~w_to;
    assign s_addr  = w_act ? ((r_owner == M_DBG) ? m1_addr : m0_addr) : '0;
    assign s_wdata = w_act ? ((r_owner == M_DBG) ? m1_wdata : m0_wdata) : '0;
    assign s_write = w_act & ((r_owner == M_DBG) ? m1_write : m0_write);
    assign w_done  = s_valid & s_ready;
    assign w_cpl   = w_done | w_to;

    assign m0_ready = w_cpl & (r_owner == M_CORE);
    assign m1_ready = w_cpl & (r_owner == M_DBG);
    assign m0_err   = w_to & (r_owner == M_CORE);
    assign m1_err   = w_to & (r_owner == M_DBG);
    assign m0_rdata = (w_done & (r_owner == M_CORE)) ? s_rdata : '0;
    assign m1_rdata = (w_done & (r_owner == M_DBG)) ? s_rdata : '0;
    assign grant    = r_grant;

    always_ff @(posedge clk)
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= M_CORE;
            r_last  <= M_DBG;
            r_grant <= 2'b00;
        end else if (r_state == ST_IDLE) begin
            if (|w_gnt) begin
                r_state <= ST_BUSY;
                r_owner <= w_gnt[1] ? M_DBG : M_CORE;
                r_last  <= w_gnt[1] ? M_DBG : M_CORE;
                r_grant <= w_gnt;
            end
        end else if (w_cpl || !w_own_valid) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
        end
endmodule
